// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between instruction fetch (IF)
//            and the load/store unit (LS). One transaction in flight at a
//            time. LS has priority, but a streak limit keeps fetch from
//            starving. flush discards an in-flight fetch return.
// Ports    : clk, rst_n (async, active low)
//            if_req/if_addr -> if_gnt, if_rvalid/if_rdata, flush
//            ls_req/ls_we/ls_be/ls_addr/ls_wdata -> ls_gnt, ls_rvalid/ls_rdata
//            mem_req/mem_we/mem_be/mem_addr/mem_wdata <- mem_ack/mem_rdata
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                flush,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [DATA_W/8-1:0] ls_be,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W     = DATA_W / 8;
  localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_LS_STREAK);
  localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY_IF = 2'd1;
  localparam logic [1:0] S_BUSY_LS = 2'd2;

  logic [1:0]          state_q, state_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                kill_q, kill_d;
  logic                mem_we_q, mem_we_d;
  logic [BE_W-1:0]     mem_be_q, mem_be_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                if_rvalid_q, if_rvalid_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic                ls_rvalid_q, ls_rvalid_d;
  logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;

  logic w_idle;
  logic w_if_prio;
  logic w_grant_ls;
  logic w_grant_if;

  // Grants are combinational and only offered from IDLE; rst_n is folded in
  // so no grant is visible while the block is held in reset.
  always_comb begin
    w_idle     = (state_q == S_IDLE) && rst_n;
    w_if_prio  = if_req && ls_req && (streak_q == STREAK_MAX);
    w_grant_ls = w_idle && ls_req && !w_if_prio;
    w_grant_if = w_idle && if_req && !w_grant_ls;
  end

  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    kill_d      = kill_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = ls_rdata_q;

    case (state_q)
      S_IDLE: begin
        if (w_grant_ls) begin
          state_d     = S_BUSY_LS;
          mem_addr_d  = ls_addr;
          mem_we_d    = ls_we;
          mem_be_d    = ls_we ? ls_be : '1;
          mem_wdata_d = ls_we ? ls_wdata : '0;
          // Streak only counts LS grants that actually made fetch wait.
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_ONE;
          end
        end else if (w_grant_if) begin
          state_d     = S_BUSY_IF;
          mem_addr_d  = if_addr;
          mem_we_d    = 1'b0;
          mem_be_d    = '1;
          mem_wdata_d = '0;
          streak_d    = '0;
          kill_d      = flush;
        end
      end
      S_BUSY_IF: begin
        if (flush) begin
          kill_d = 1'b1;
        end
        if (mem_ack) begin
          state_d = S_IDLE;
          kill_d  = 1'b0;
          // A flush in the ack cycle itself must also suppress the return.
          if (!kill_q && !flush) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end
        end
      end
      S_BUSY_LS: begin
        if (mem_ack) begin
          state_d     = S_IDLE;
          ls_rvalid_d = 1'b1;
          ls_rdata_d  = mem_we_q ? '0 : mem_rdata;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      streak_q    <= '0;
      kill_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      streak_q    <= streak_d;
      kill_q      <= kill_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
    end
  end

  assign if_gnt    = w_grant_if;
  assign ls_gnt    = w_grant_ls;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = (state_q != S_IDLE);
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Directed vector table
//            plus hand-written sequences for streak, flush and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        flush;
  logic        ls_req;
  logic        ls_we;
  logic [3:0]  ls_be;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(
    .ADDR_W       (32),
    .DATA_W       (32),
    .MAX_LS_STREAK(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_gnt   (if_gnt),
    .if_rvalid(if_rvalid),
    .if_rdata (if_rdata),
    .flush    (flush),
    .ls_req   (ls_req),
    .ls_we    (ls_we),
    .ls_be    (ls_be),
    .ls_addr  (ls_addr),
    .ls_wdata (ls_wdata),
    .ls_gnt   (ls_gnt),
    .ls_rvalid(ls_rvalid),
    .ls_rdata (ls_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        flush;
    logic        mem_ack;
    logic [31:0] mem_rdata;
  } in_t;

  typedef struct packed {
    logic        if_gnt;
    logic        ls_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        ls_rvalid;
    logic [31:0] ls_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];
  out_t act;

  int n_cmp;
  int n_bad;

  assign act = '{if_gnt, ls_gnt, if_rvalid, if_rdata, ls_rvalid, ls_rdata,
                 mem_req, mem_we, mem_be, mem_addr, mem_wdata};

  task automatic chk(input string name, input logic [191:0] got, input logic [191:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic apply(input in_t v);
    if_req    = v.if_req;
    if_addr   = v.if_addr;
    ls_req    = v.ls_req;
    ls_we     = v.ls_we;
    ls_be     = v.ls_be;
    ls_addr   = v.ls_addr;
    ls_wdata  = v.ls_wdata;
    flush     = v.flush;
    mem_ack   = v.mem_ack;
    mem_rdata = v.mem_rdata;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_be = '0;
    ls_addr = '0; ls_wdata = '0; flush = 0; mem_ack = 0; mem_rdata = '0;
  endtask

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Let any outstanding transaction finish with an immediate ack.
  task automatic drain();
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      idle_inputs();
      mem_ack = mem_req;
    end
    @(negedge clk);
    chk("drain_idle", {191'd0, mem_req}, 192'd0);
  endtask

  logic exp_ls_seq [10];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    idle_inputs();

    // Directed table: tests IF-only read, LS-vs-IF contention, store.
    vecs[0]  = '{'{1, 32'h100, 0, 0, 4'h0, 32'h0,   32'h0,    0, 0, 32'h0},
                 '{1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 4'h0, 32'h0,   32'h0}};
    vecs[1]  = '{'{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,    0, 0, 32'h0},
                 '{0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 4'hF, 32'h100, 32'h0}};
    vecs[2]  = vecs[1];
    vecs[3]  = '{'{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,    0, 1, 32'hDEADBEEF},
                 '{0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 4'hF, 32'h100, 32'h0}};
    vecs[4]  = '{'{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,    0, 0, 32'h0},
                 '{0, 0, 1, 32'hDEADBEEF, 0, 32'h0,        0, 0, 4'hF, 32'h100, 32'h0}};
    vecs[5]  = '{'{1, 32'h300, 1, 0, 4'h0, 32'h200, 32'h0,    0, 0, 32'h0},
                 '{0, 1, 0, 32'hDEADBEEF, 0, 32'h0,        0, 0, 4'hF, 32'h100, 32'h0}};
    vecs[6]  = '{'{1, 32'h300, 0, 0, 4'h0, 32'h0,   32'h0,    0, 1, 32'hCAFEF00D},
                 '{0, 0, 0, 32'hDEADBEEF, 0, 32'h0,        1, 0, 4'hF, 32'h200, 32'h0}};
    vecs[7]  = '{'{1, 32'h300, 0, 0, 4'h0, 32'h0,   32'h0,    0, 0, 32'h0},
                 '{1, 0, 0, 32'hDEADBEEF, 1, 32'hCAFEF00D, 0, 0, 4'hF, 32'h200, 32'h0}};
    vecs[8]  = '{'{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,    0, 1, 32'h11111111},
                 '{0, 0, 0, 32'hDEADBEEF, 0, 32'hCAFEF00D, 1, 0, 4'hF, 32'h300, 32'h0}};
    vecs[9]  = '{'{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,    0, 0, 32'h0},
                 '{0, 0, 1, 32'h11111111, 0, 32'hCAFEF00D, 0, 0, 4'hF, 32'h300, 32'h0}};
    vecs[10] = '{'{0, 32'h0,   1, 1, 4'h3, 32'h40,  32'h1234, 0, 0, 32'h0},
                 '{0, 1, 0, 32'h11111111, 0, 32'hCAFEF00D, 0, 0, 4'hF, 32'h300, 32'h0}};
    vecs[11] = '{'{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,    0, 1, 32'h55555555},
                 '{0, 0, 0, 32'h11111111, 0, 32'hCAFEF00D, 1, 1, 4'h3, 32'h40,  32'h1234}};
    vecs[12] = '{'{0, 32'h0,   0, 0, 4'h0, 32'h0,   32'h0,    0, 0, 32'h0},
                 '{0, 0, 0, 32'h11111111, 1, 32'h0,        0, 1, 4'h3, 32'h40,  32'h1234}};

    exp_ls_seq = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    // Reset state
    #2;
    chk("reset_outputs", {54'd0, act}, 192'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table-driven vectors
    for (int v = 0; v < NVEC; v++) begin
      next_cycle();
      apply(vecs[v].i);
      @(negedge clk);
      chk($sformatf("vec%0d", v), {54'd0, act}, {54'd0, vecs[v].o});
    end
    drain();

    // Streak limit: both requesters held, memory acks immediately.
    begin
      int g;
      g = 0;
      for (int c = 0; c < 40 && g < 10; c++) begin
        next_cycle();
        if_req = 1; if_addr = 32'h900;
        ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h800;
        flush = 0; mem_rdata = 32'h0;
        mem_ack = mem_req;
        @(negedge clk);
        if (if_gnt || ls_gnt) begin
          chk($sformatf("streak_grant%0d", g), {190'd0, if_gnt, ls_gnt},
              {190'd0, !exp_ls_seq[g], exp_ls_seq[g]});
          g++;
        end
      end
      if (g < 10) chk("streak_timeout", 192'(g), 192'd10);
    end
    drain();

    // Flush during BUSY_IF: transaction completes, return suppressed.
    next_cycle();
    idle_inputs(); if_req = 1; if_addr = 32'h500;
    @(negedge clk);
    chk("flush_gnt", {191'd0, if_gnt}, 192'd1);
    next_cycle();
    idle_inputs();
    next_cycle();
    flush = 1;
    @(negedge clk);
    chk("flush_memreq_held", {159'd0, mem_req, mem_addr}, {159'd1, 32'h500});
    next_cycle();
    flush = 0; mem_ack = 1; mem_rdata = 32'h77777777;
    @(negedge clk);
    chk("flush_memreq_ack", {191'd0, mem_req}, 192'd1);
    next_cycle();
    idle_inputs(); if_req = 1; if_addr = 32'h504;
    @(negedge clk);
    chk("flush_no_rvalid", {190'd0, if_rvalid, if_gnt}, {190'd0, 1'b0, 1'b1});
    next_cycle();
    idle_inputs(); mem_ack = 1; mem_rdata = 32'h88888888;
    @(negedge clk);
    chk("refetch_addr", {159'd0, mem_req, mem_addr}, {159'd1, 32'h504});
    next_cycle();
    idle_inputs();
    @(negedge clk);
    chk("refetch_rvalid", {159'd0, if_rvalid, if_rdata}, {159'd1, 32'h88888888});

    // Asynchronous reset in the middle of a load.
    next_cycle();
    idle_inputs(); ls_req = 1; ls_addr = 32'h600;
    @(negedge clk);
    chk("rst_ls_gnt", {191'd0, ls_gnt}, 192'd1);
    next_cycle();
    idle_inputs(); mem_ack = 1; mem_rdata = 32'h99999999;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_outputs", {54'd0, act}, 192'd0);
    next_cycle();
    rst_n = 1'b1;
    idle_inputs();
    @(negedge clk);
    chk("rst_release_quiet", {190'd0, mem_req, ls_rvalid}, 192'd0);
    next_cycle();
    idle_inputs(); ls_req = 1; ls_we = 1; ls_be = 4'h1; ls_addr = 32'h44;
    @(negedge clk);
    chk("rst_idle_gnt", {190'd0, ls_gnt, ls_rvalid}, {190'd0, 1'b1, 1'b0});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
